// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the UART transmit arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/UART side.
interface uart_tx_arbiter_if;
    logic        enable;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic        uart_we;
    logic        uart_en;
    logic [7:0]  uart_data;
    logic        uart_tx_busy;
    logic        uart_tx_done;

    modport master (
        output enable, req, last, data, uart_tx_busy, uart_tx_done,
        input  ack, grant_valid, grant_id, uart_we, uart_en, uart_data
    );

    modport slave (
        input  enable, req, last, data, uart_tx_busy, uart_tx_done,
        output ack, grant_valid, grant_id, uart_we, uart_en, uart_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among 4 requesters, locking the owner for multi-byte messages.
// Grant one cycle after a request is seen with the UART idle; requesters hold req/data until their ack pulse.
module uart_tx_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  rr_ptr;
    logic [1:0]  grant_id_q;
    logic [1:0]  pick_id;
    logic        pick_vld;
    logic [15:0] cnt;
    logic [7:0]  cap_byte;
    logic        cap_last;
    logic [3:0]  ack_q;
    logic        start;
    logic        resume;
    logic        done_ev;
    logic        timeout;
    logic        we;
    logic        gv;

    // Scan downwards so the nearest requester at or after rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[rr_ptr + 2'(k)]) begin
                pick_vld = 1'b1;
                pick_id  = rr_ptr + 2'(k);
            end
        end
    end

    assign start   = (state == IDLE) && bus.enable && pick_vld && !bus.uart_tx_busy;
    assign resume  = (state == HOLD) && bus.enable && bus.req[grant_id_q] && !bus.uart_tx_busy;
    assign done_ev = (state == WAIT) && bus.uart_tx_done;
    assign timeout = (state == HOLD) && !resume && (cnt == 16'(LOCK_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)              state_nxt = LOAD;
            LOAD: if (bus.uart_tx_busy)   state_nxt = WAIT;
            WAIT: if (done_ev)            state_nxt = cap_last ? IDLE : HOLD;
            HOLD: begin
                if (resume)               state_nxt = LOAD;
                else if (timeout)         state_nxt = IDLE;
            end
            default:                      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        we = (state == LOAD);
        gv = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= 2'd0;
            cnt        <= 16'd0;
            cap_byte   <= 8'd0;
            cap_last   <= 1'b0;
            grant_id_q <= 2'd0;
            ack_q      <= 4'd0;
        end else begin
            ack_q <= 4'd0;
            if (start) begin
                grant_id_q <= pick_id;
                cap_byte   <= bus.data[{pick_id, 3'b000} +: 8];
                cap_last   <= bus.last[pick_id];
            end
            if (resume) begin
                cap_byte <= bus.data[{grant_id_q, 3'b000} +: 8];
                cap_last <= bus.last[grant_id_q];
            end
            if (done_ev) begin
                ack_q <= 4'b0001 << grant_id_q;
                if (cap_last) begin
                    rr_ptr <= grant_id_q + 2'd1;
                end
            end
            if (timeout) begin
                rr_ptr <= grant_id_q + 2'd1;
            end
            // Saturating count; release fires long before the ceiling.
            if (done_ev || resume) begin
                cnt <= 16'd0;
            end else if ((state == HOLD) && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant_valid = gv;
    assign bus.grant_id    = grant_id_q;
    assign bus.uart_we     = we;
    assign bus.uart_en     = bus.enable;
    assign bus.uart_data   = cap_byte;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART, byte/ack scoreboards, round-robin table and corner-case sequences.
module tb_uart_tx_arbiter;
    localparam int BUSY_CYC = 5;

    typedef struct {
        logic [3:0] req;
        int         exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [9:0] exp_byte_q[$];
    int         exp_ack_q[$];
    vec_t       tbl[9];

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.LOCK_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting, got no event expected one", name);
    endtask

    task automatic push(input int id, input logic [7:0] b, input bit with_ack);
        exp_byte_q.push_back({2'(id), b});
        if (with_ack) exp_ack_q.push_back(id);
    endtask

    // Run until every requester is served and the UART is idle; requesters drop req on their ack.
    task automatic drain(input bit all_on_ack, input string name);
        int n = 0;
        while ((bus.req != 4'd0 || bus.grant_valid || bus.uart_tx_busy) && n < 400) begin
            @(negedge clk); #1;
            n++;
            if (bus.ack != 4'd0) bus.req = all_on_ack ? 4'd0 : (bus.req & ~bus.ack);
        end
        if (n >= 400) expire(name);
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        while (!bus.grant_valid && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!bus.grant_valid) expire(name);
    endtask

    // Behavioural UART transmitter; every accepted write is compared with the byte scoreboard.
    logic [9:0] eb;
    int         left;
    initial begin
        bus.uart_tx_busy = 1'b0;
        bus.uart_tx_done = 1'b0;
        left = 0;
        forever begin
            @(negedge clk);
            if (bus.uart_we) begin
                if (bus.uart_tx_busy) begin
                    expire("we_while_busy");
                end else begin
                    if (exp_byte_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL byte_unexpected: got id%0d byte %0h expected none", bus.grant_id, bus.uart_data);
                    end else begin
                        eb = exp_byte_q.pop_front();
                        check("byte_id_data", 32'({bus.grant_id, bus.uart_data}), 32'(eb));
                    end
                    bus.uart_tx_busy = 1'b1;
                    left = BUSY_CYC;
                end
            end else if (bus.uart_tx_done) begin
                bus.uart_tx_done = 1'b0;
                bus.uart_tx_busy = 1'b0;
            end else if (bus.uart_tx_busy) begin
                left--;
                if (left == 0) bus.uart_tx_done = 1'b1;
            end
        end
    end

    int ea;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.ack != 4'd0) begin
                check("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
                if (exp_ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: got ack=%b expected none", bus.ack);
                end else begin
                    ea = exp_ack_q.pop_front();
                    check("ack_id", 32'(bus.ack), 32'(4'b0001 << ea));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    int         n;
    int         hold;
    bit         seen;
    logic       pb;
    logic [7:0] xb;

    initial begin
        // rr_ptr starts at 1 after the first scenario; each row advances it past the winner.
        tbl[0] = '{4'b0001, 0};
        tbl[1] = '{4'b0011, 1};
        tbl[2] = '{4'b0011, 0};
        tbl[3] = '{4'b1100, 2};
        tbl[4] = '{4'b1100, 3};
        tbl[5] = '{4'b1010, 1};
        tbl[6] = '{4'b1001, 3};
        tbl[7] = '{4'b1111, 0};
        tbl[8] = '{4'b1000, 3};

        rst = 1'b1;
        bus.enable = 1'b0;
        bus.req    = 4'd0;
        bus.last   = 4'd0;
        bus.data   = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_uart_we", 32'(bus.uart_we), 32'd0);
        check("rst_uart_data", 32'(bus.uart_data), 32'd0);
        check("rst_uart_en", 32'(bus.uart_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.enable = 1'b1;
        #1;
        check("uart_en_follows", 32'(bus.uart_en), 32'd1);

        // Single requester 0, single byte.
        bus.data = 32'h00000041;
        bus.last = 4'b0001;
        push(0, 8'h41, 1);
        bus.req = 4'b0001;
        drain(0, "single_byte");
        check("single_grant_dropped", 32'(bus.grant_valid), 32'd0);

        // Round-robin table.
        for (int i = 0; i < 9; i++) begin
            bus.data = 32'h03020100 + 32'(i) * 32'h10101010;
            bus.last = 4'hF;
            xb = 8'(i * 16 + tbl[i].exp_id);
            push(tbl[i].exp_id, xb, 1);
            bus.req = tbl[i].req;
            drain(1, "rr_table");
        end

        // All four requesting: served 0,1,2,3, then the next round starts at 0.
        bus.data = 32'hA3A2A1A0;
        bus.last = 4'hF;
        for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i), 1);
        bus.req = 4'hF;
        drain(0, "all_four");
        bus.data = 32'hB3B2B1B0;
        push(0, 8'hB0, 1);
        bus.req = 4'hF;
        drain(1, "next_round");

        // Requester 2 sends "OK" as one locked message while requester 1 waits.
        bus.data = {8'h00, 8'h4F, 8'h55, 8'h00};
        bus.last = 4'b0010;
        push(2, 8'h4F, 1);
        push(2, 8'h4B, 1);
        push(1, 8'h55, 1);
        bus.req = 4'b0100;
        wait_grant("ok_grant");
        bus.req = 4'b0110;
        n = 0;
        while ((bus.req != 4'd0 || bus.grant_valid || bus.uart_tx_busy) && n < 400) begin
            @(negedge clk); #1;
            n++;
            if (bus.ack[2] && !bus.last[2]) begin
                bus.data[23:16] = 8'h4B;
                bus.last[2] = 1'b1;
            end else if (bus.ack != 4'd0) begin
                bus.req = bus.req & ~bus.ack;
            end
        end
        if (n >= 400) expire("ok_message");

        // Owner 3 abandons its message; the lock expires after LOCK_TIMEOUT cycles.
        bus.data = 32'h33000000;
        bus.last = 4'b0000;
        push(3, 8'h33, 1);
        push(0, 8'h30, 1);
        bus.req = 4'b1000;
        wait_grant("lock_grant");
        bus.data[7:0] = 8'h30;
        bus.last[0] = 1'b1;
        bus.req = 4'b1001;
        n = 0;
        while (!bus.ack[3] && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!bus.ack[3]) expire("lock_ack");
        bus.req[3] = 1'b0;
        hold = 0;
        while (bus.grant_valid && bus.grant_id == 2'd3 && n < 400) begin
            hold++;
            @(negedge clk); #1;
            n++;
        end
        check("hold_cycles", 32'(hold), 32'd8);
        wait_grant("grant_after_release");
        check("grant_id_after_release", 32'(bus.grant_id), 32'd0);
        drain(0, "after_release");

        // Reset in the middle of WAIT: everything clears, no ack, regrant waits for the UART.
        bus.data = 32'h00770000;
        bus.last = 4'b0100;
        push(2, 8'h77, 0);
        bus.req = 4'b0100;
        n = 0;
        while (!bus.uart_we && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!bus.uart_we) expire("rst_load");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ack", 32'(bus.ack), 32'd0);
        check("midrst_grant_valid", 32'(bus.grant_valid), 32'd0);
        check("midrst_grant_id", 32'(bus.grant_id), 32'd0);
        check("midrst_uart_we", 32'(bus.uart_we), 32'd0);
        check("midrst_uart_data", 32'(bus.uart_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(2, 8'h77, 1);
        seen = 1'b0;
        pb = 1'b1;
        n = 0;
        while (!seen && n < 200) begin
            @(posedge clk);
            pb = bus.uart_tx_busy;
            #1;
            n++;
            if (bus.grant_valid) seen = 1'b1;
        end
        if (!seen) expire("post_rst_grant");
        else check("post_rst_busy_at_grant", 32'(pb), 32'd0);
        drain(0, "post_rst");

        // Disabled arbiter holds off a pending request until enable returns.
        bus.enable = 1'b0;
        bus.data = 32'h00002200;
        bus.last = 4'b0010;
        bus.req = 4'b0010;
        repeat (5) @(negedge clk);
        #1;
        check("disabled_no_grant", 32'(bus.grant_valid), 32'd0);
        check("disabled_uart_en", 32'(bus.uart_en), 32'd0);
        push(1, 8'h22, 1);
        @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk); #1;
        check("enable_grant_valid", 32'(bus.grant_valid), 32'd1);
        check("enable_grant_id", 32'(bus.grant_id), 32'd1);
        check("enable_uart_en", 32'(bus.uart_en), 32'd1);
        drain(0, "enable_drain");

        repeat (5) @(negedge clk);
        check("byte_queue_empty", 32'(exp_byte_q.size()), 32'd0);
        check("ack_queue_empty", 32'(exp_ack_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 1024, is the clk cycles a locked requester may leave req low before the lock is released; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 enable  input  1  global enable; drives uart_en directly (combinational).
REQ-005 req  input  4  per-requester byte request; requester i holds req[i]=1 and data until ack[i].
REQ-006 last  input  4  last[i]=1 marks the pending byte of requester i as the final byte of its message.
REQ-007 data  input  32  packed bytes; requester i uses data[8i+7:8i].
REQ-008 ack  output  4  one-cycle pulse on ack[i] when requester i's byte has completed transmission.
REQ-009 grant_valid  output  1  high while a requester owns the transmitter.
REQ-010 grant_id  output  2  index of the owning requester; meaningful only when grant_valid=1.
REQ-011 uart_we  output  1  write strobe to the UART transmitter.
REQ-012 uart_en  output  1  enable to the UART; equals enable.
REQ-013 uart_data  output  8  byte presented to the UART; registered.
REQ-014 uart_tx_busy  input  1  UART transmitter busy, high from start bit until return to idle.
REQ-015 uart_tx_done  input  1  UART one-cycle pulse at end of stop bit.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WAIT, HOLD.
REQ-017 IDLE: when enable=1, any req bit=1 and uart_tx_busy=0, pick the first requesting index at or after rr_ptr (modulo 4), capture its data and last, set grant_id and grant_valid=1, then go to LOAD.
REQ-018 LOAD: uart_we=1 and uart_data = the captured byte, held stable. Go to WAIT on the first cycle uart_tx_busy=1.
REQ-019 WAIT: uart_we=0. On uart_tx_done=1, pulse ack[grant_id] for exactly one cycle, on the cycle after the done pulse.
REQ-019a WAIT on uart_tx_done, captured last=1: go to IDLE, grant_valid=0, rr_ptr = grant_id+1 (wraps 3->0).
REQ-019b WAIT on uart_tx_done, captured last=0: go to HOLD, timeout counter cleared.
REQ-020 HOLD: only the owner is serviced.
REQ-020a HOLD, owner req=1 and uart_tx_busy=0: capture the owner's data and last, go to LOAD, clear the counter.
REQ-020b HOLD otherwise: increment the counter. At LOCK_TIMEOUT-1, release to IDLE and advance rr_ptr as in REQ-019a.
REQ-021 The timeout counter SHALL be 16 bits wide and SHALL not wrap.
REQ-022 Requests from non-owners during LOAD/WAIT/HOLD SHALL be ignored and not acknowledged.
REQ-023 enable=0 SHALL block new grants in IDLE and HOLD.
REQ-024 enable=0 SHALL NOT abort LOAD or WAIT; an in-flight byte completes and is acknowledged.
REQ-025 uart_we SHALL never be asserted while uart_tx_busy=1 before the LOAD phase of the current byte.
REQ-026 At most one ack bit SHALL be high per cycle.
REQ-027 Simultaneous requests in IDLE SHALL be resolved in the same cycle by the round-robin order of REQ-017.

Reset
REQ-028 rst=1 SHALL asynchronously force: state=IDLE, rr_ptr=0, counter=0, captured byte=0, ack=0, grant_valid=0, grant_id=0, uart_we=0, uart_data=0.
REQ-029 Reset during LOAD/WAIT SHALL drop the grant without ack.
REQ-029a After rst deasserts, the first grant SHALL wait for uart_tx_busy=0.

Verification
REQ-030 Bench scenario: req=0001, data[7:0]=0x41, last[0]=1 -> uart_data=0x41 with uart_we until tx_busy; one ack[0] pulse after tx_done; grant_valid=0; rr_ptr=1.
REQ-031 Bench scenario: req=1111, all last=1, four bytes 0xA0..0xA3 -> bytes sent in order 0,1,2,3; next round starts at 0.
REQ-032 Bench scenario: req[2] sends "OK" with last=0 then last=1 while req[1] is held high -> 'O','K' sent back-to-back for requester 2; requester 1 granted only after, with no byte interleaved.
REQ-033 Bench scenario: LOCK_TIMEOUT=8; owner 3 drops req after a last=0 byte -> release exactly 8 cycles into HOLD; waiting requester 0 is then granted.
REQ-034 Bench scenario: rst pulsed mid-WAIT -> all outputs 0 immediately; no ack; next grant only after tx_busy=0.
REQ-035 Bench scenario: enable=0 with req=0010 pending -> no grant and uart_en=0; enable=1 -> grant within 1 cycle when tx_busy=0.
